if_inst_queue: RTL and testbench
================================

// Module: if_inst_queue
// PURPOSE
//  Instruction fetch queue between ifu and the decode stage (if/id).
//  - Buffers {pc, inst, trap} words produced by ifu.
//  - Decouples icache/MMU fetch latency from decode stalls.
//  - Stops the fetch stream after a trapped word.
//  - Provides the full-stall request to pc_reg and flushes on redirect.
// PARAMETERS
//  DEPTH    4          entries; power of two, >=2
//  PTR_W    $clog2(DEPTH)  pointer width; localparam, not overridable
// PORTS
//  clk          in   1          core clock
//  rst_n        in   1          asynchronous active-low reset
//  enq_valid_i  in   1          ifu word valid (ifu if_rdata_valid_i)
//  enq_ready_o  out  1          queue accepts a word this cycle
//  enq_pc_i     in   32         ifu inst_addr_o
//  enq_inst_i   in   32         ifu inst_data_o
//  enq_trap_i   in   `TRAP_LEN  ifu trap_bus_o
//  deq_valid_o  out  1          head entry valid to if/id
//  deq_ready_i  in   1          decode consumes head (= !id_stall)
//  deq_pc_o     out  32         head pc
//  deq_inst_o   out  32         head instruction
//  deq_trap_o   out  `TRAP_LEN  head trap bus
//  flush_i      in   1          redirect/flush (branch mispredict, trap, fence.i)
//  full_stall_o out  1          = !enq_ready_o; stall request to pc_reg
//  count_o      out  PTR_W+1    occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count_o=0, trap_lock=0.
//    Storage is zeroed; deq_valid_o=0; deq_pc/inst/trap_o=0; enq_ready_o=1.
//  - Circular buffer. Pointers are PTR_W bits and wrap modulo DEPTH.
//    count is tracked separately: 0 = empty, DEPTH = full.
//  - enq fire = enq_valid_i & enq_ready_o & !flush_i.
//    It writes entry[wr_ptr] and increments wr_ptr.
//  - deq fire = deq_valid_o & deq_ready_i. It increments rd_ptr.
//  - Simultaneous enq and deq: count unchanged, both pointers advance.
//  - enq_ready_o = (count != DEPTH) & !trap_lock.
//    No write-through when full, even if deq fires in the same cycle.
//  - deq_valid_o = (count != 0) & !flush_i.
//    deq_pc/inst/trap_o = entry[rd_ptr], combinational read.
//  - Latency: a word enqueued in cycle N is visible at the head in N+1 if the
//    queue was empty.
//  - Trap lock:
//    - Set on an enq fire where |enq_trap_i.
//    - Cleared when that entry deq-fires, or on flush_i.
//    - While set, enq_ready_o=0, so no words follow a faulting fetch.
//  - Flush:
//    - Highest priority. The enq of the flush cycle is dropped, and no deq
//      fires (deq_valid_o=0).
//    - Next cycle: count=0, pointers=0, trap_lock=0.
//    - Storage contents are don't-care.
//  - Data is held stable at the head while deq_valid_o=1 & deq_ready_i=0.
//  - Reset asserted mid-operation discards all entries immediately.
//    Outputs take their reset values asynchronously.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//   - When count==0 & enq_valid_i & !flush_i & !trap_lock:
//     - deq_valid_o=1 and deq_*_o = enq_*_i in the same cycle (zero latency).
//     - If deq_ready_i=1, the word is consumed and not written; count stays 0.
//     - If deq_ready_i=0, the word is written normally.
//     - If the bypassed word carries a trap and is consumed, trap_lock is not
//       set.
//  IFQ_BYPASS_EN undefined:
//   - No bypass. Minimum enqueue-to-head latency is 1 cycle.
// TESTING
//  1. Reset, then enq pc=0x8000_0000 inst=0x0000_0013 with deq_ready=1.
//     -> deq_valid=1 next cycle with the same pc/inst; count returns to 0.
//  2. deq_ready=0, enq 4 words pc=0x80000000..0x8000000C.
//     -> count=4, enq_ready=0, full_stall=1.
//     Then deq_ready=1 -> words out in order, one per cycle.
//  3. Full queue, enq_valid=1 and deq_ready=1 in the same cycle.
//     -> only the deq fires; count 4->3; the enq word is re-presented and
//        accepted next cycle.
//  4. 3 entries queued, flush_i=1 with enq_valid=1.
//     -> deq_valid=0 that cycle; next cycle count=0, enq_ready=1; the flushed
//        enq word never appears.
//  5. Enq a word with the TRAP_INST_PAGE_FAULT bit set, then enq_valid held 1.
//     -> enq_ready=0 until that entry deq-fires; the head trap bus matches.
//  6. rst_n pulsed low mid-stream with count=2.
//     -> count_o=0, deq_valid=0, deq_pc=0 immediately, without waiting for a
//        clock edge.
//  Additional case with IFQ_BYPASS_EN: empty queue, enq + deq_ready same
//  cycle -> deq_pc=enq_pc in that cycle; count stays 0.

Source files
------------

// File: rtl/if_inst_queue.sv
// if_inst_queue: instruction fetch queue between the ifu and the if/id stage.
// It buffers {pc, inst, trap} words in a small circular buffer and stops
// accepting fetches after a trapped word until that word is consumed. It also
// raises full_stall_o towards pc_reg and empties itself on a redirect flush.
// Optional feature: define IFQ_BYPASS_EN to let a word fetched into an empty
// queue appear at the head in the same cycle.
// TRAP_LEN defaults to 4 when the core has not defined it.

`ifndef TRAP_LEN
`define TRAP_LEN 4
`endif

module if_inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  input  logic [31:0]          enq_pc_i,
  input  logic [31:0]          enq_inst_i,
  input  logic [`TRAP_LEN-1:0] enq_trap_i,
  output logic                 deq_valid_o,
  input  logic                 deq_ready_i,
  output logic [31:0]          deq_pc_o,
  output logic [31:0]          deq_inst_o,
  output logic [`TRAP_LEN-1:0] deq_trap_o,
  input  logic                 flush_i,
  output logic                 full_stall_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [`TRAP_LEN-1:0] trap;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             lock_q, lock_d;

  entry_t head;
  logic   occupied;
  logic   enq_fire;
  logic   deq_fire;
  logic   bypass_take;
  logic   wr_en;
  logic   rd_en;

  // Handshake, head selection and which side of the buffer actually moves.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    occupied     = (count_q != '0);
    // A full queue never writes through, even when the head leaves this cycle.
    enq_ready_o  = (count_q != FULL_CNT) & ~lock_q;
    full_stall_o = ~enq_ready_o;
    enq_fire     = enq_valid_i & enq_ready_o & ~flush_i;
`ifdef IFQ_BYPASS_EN
    // An empty, unlocked queue forwards the incoming word straight to decode.
    if (~occupied & enq_valid_i & ~flush_i & ~lock_q) begin
      deq_valid_o = 1'b1;
      deq_pc_o    = enq_pc_i;
      deq_inst_o  = enq_inst_i;
      deq_trap_o  = enq_trap_i;
      bypass_take = deq_ready_i;
    end else begin
      deq_valid_o = occupied & ~flush_i;
      deq_pc_o    = head.pc;
      deq_inst_o  = head.inst;
      deq_trap_o  = head.trap;
      bypass_take = 1'b0;
    end
`else
    deq_valid_o = occupied & ~flush_i;
    deq_pc_o    = head.pc;
    deq_inst_o  = head.inst;
    deq_trap_o  = head.trap;
    bypass_take = 1'b0;
`endif
    deq_fire = deq_valid_o & deq_ready_i;
    // A consumed bypass word touches neither storage nor pointers.
    wr_en    = enq_fire & ~bypass_take;
    rd_en    = deq_fire & ~bypass_take;
    count_o  = count_q;
  end

  // Next-state for storage, pointers, occupancy and the trap lock.
  always_comb begin
    // NOTE: every *_d gets a default before any branch, so no path leaves a
    // variable unassigned and no latch is inferred; combinational logic uses
    // blocking '=', while the flops below use non-blocking '<='.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lock_d   = lock_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      lock_d   = 1'b0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = '{pc: enq_pc_i, inst: enq_inst_i, trap: enq_trap_i};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // The trapped word is always the youngest entry, so it leaves when the
      // last remaining entry is dequeued.
      if (wr_en & (|enq_trap_i)) begin
        lock_d = 1'b1;
      end else if (rd_en & lock_q & (count_q == ONE_CNT)) begin
        lock_d = 1'b0;
      end
    end
  end

  // State registers; reset discards every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too, so the head outputs read zero while empty.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lock_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lock_q   <= lock_d;
    end
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// tb_if_inst_queue: directed-vector bench for if_inst_queue (DEPTH = 4).
// Inputs change 1 ns after a rising edge. Outputs are sampled 3 ns later,
// before the next rising edge.

`ifndef TRAP_LEN
`define TRAP_LEN 4
`endif

module tb_if_inst_queue;

  localparam int TRAP_INST_PAGE_FAULT = 1;

  logic                 clk;
  logic                 rst_n;
  logic                 enq_valid_i;
  logic                 enq_ready_o;
  logic [31:0]          enq_pc_i;
  logic [31:0]          enq_inst_i;
  logic [`TRAP_LEN-1:0] enq_trap_i;
  logic                 deq_valid_o;
  logic                 deq_ready_i;
  logic [31:0]          deq_pc_o;
  logic [31:0]          deq_inst_o;
  logic [`TRAP_LEN-1:0] deq_trap_o;
  logic                 flush_i;
  logic                 full_stall_o;
  logic [2:0]           count_o;

  int n_cmp;
  int n_bad;

  if_inst_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .enq_pc_i    (enq_pc_i),
    .enq_inst_i  (enq_inst_i),
    .enq_trap_i  (enq_trap_i),
    .deq_valid_o (deq_valid_o),
    .deq_ready_i (deq_ready_i),
    .deq_pc_o    (deq_pc_o),
    .deq_inst_o  (deq_inst_o),
    .deq_trap_o  (deq_trap_o),
    .flush_i     (flush_i),
    .full_stall_o(full_stall_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge, then let the comb logic settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive_enq(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [`TRAP_LEN-1:0] trap);
    enq_valid_i = v;
    enq_pc_i    = pc;
    enq_inst_i  = inst;
    enq_trap_i  = trap;
  endtask

  logic [`TRAP_LEN-1:0] pf_trap;
  logic [31:0]          exp_pc [5];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pf_trap = '0;
    pf_trap[TRAP_INST_PAGE_FAULT] = 1'b1;
    exp_pc = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h9000_0000};

    rst_n = 1'b0;
    drive_enq(1'b0, '0, '0, '0);
    deq_ready_i = 1'b0;
    flush_i     = 1'b0;

    // Reset state
    #3;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_deq_valid", 64'(deq_valid_o), 64'd0);
    check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    check("rst_full_stall", 64'(full_stall_o), 64'd0);
    check("rst_deq_pc", 64'(deq_pc_o), 64'd0);
    #4 rst_n = 1'b1;
    cyc();

`ifndef IFQ_BYPASS_EN
    // 1: single word, one-cycle latency, consumed right away
    drive_enq(1'b1, 32'h8000_0000, 32'h0000_0013, '0);
    deq_ready_i = 1'b1;
    settle();
    check("t1_valid_same_cycle", 64'(deq_valid_o), 64'd0);
    cyc();
    drive_enq(1'b0, '0, '0, '0);
    settle();
    check("t1_deq_valid", 64'(deq_valid_o), 64'd1);
    check("t1_deq_pc", 64'(deq_pc_o), 64'h8000_0000);
    check("t1_deq_inst", 64'(deq_inst_o), 64'h0000_0013);
    check("t1_count", 64'(count_o), 64'd1);
    cyc();
    settle();
    check("t1_count_drained", 64'(count_o), 64'd0);
    check("t1_valid_drained", 64'(deq_valid_o), 64'd0);
    cyc();
`else
    // Bypass: empty queue, enq and deq in the same cycle
    drive_enq(1'b1, 32'hF000_0000, 32'h0000_0013, '0);
    deq_ready_i = 1'b1;
    settle();
    check("byp_deq_valid", 64'(deq_valid_o), 64'd1);
    check("byp_deq_pc", 64'(deq_pc_o), 64'hF000_0000);
    cyc();
    drive_enq(1'b0, '0, '0, '0);
    settle();
    check("byp_count", 64'(count_o), 64'd0);
    check("byp_valid_after", 64'(deq_valid_o), 64'd0);
    cyc();
`endif

    // 2: fill to DEPTH with decode stalled
    deq_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, exp_pc[i], 32'h100 + 32'(i), '0);
      cyc();
    end
    drive_enq(1'b0, '0, '0, '0);
    settle();
    check("t2_count_full", 64'(count_o), 64'd4);
    check("t2_enq_ready", 64'(enq_ready_o), 64'd0);
    check("t2_full_stall", 64'(full_stall_o), 64'd1);
    check("t2_head_inst", 64'(deq_inst_o), 64'h100);

    // 3: full queue, enq and deq together -> only deq fires
    drive_enq(1'b1, 32'h9000_0000, 32'h200, '0);
    deq_ready_i = 1'b1;
    settle();
    check("t3_enq_ready_full", 64'(enq_ready_o), 64'd0);
    check("t3_head_pc0", 64'(deq_pc_o), 64'(exp_pc[0]));
    cyc();
    settle();
    check("t3_count_after_deq", 64'(count_o), 64'd3);
    check("t3_enq_ready_again", 64'(enq_ready_o), 64'd1);
    check("t3_head_pc1", 64'(deq_pc_o), 64'(exp_pc[1]));
    cyc();
    drive_enq(1'b0, '0, '0, '0);
    settle();
    check("t3_count_enq_deq", 64'(count_o), 64'd3);
    for (int i = 2; i < 5; i++) begin
      check($sformatf("t3_order_pc%0d", i), 64'(deq_pc_o), 64'(exp_pc[i]));
      check($sformatf("t3_order_valid%0d", i), 64'(deq_valid_o), 64'd1);
      cyc();
      settle();
    end
    check("t3_drained", 64'(count_o), 64'd0);
    deq_ready_i = 1'b0;
    cyc();

    // 4: flush with 3 entries and a word presented
    for (int i = 0; i < 3; i++) begin
      drive_enq(1'b1, 32'hA000_0000 + 32'(4 * i), 32'h300 + 32'(i), '0);
      cyc();
    end
    drive_enq(1'b1, 32'hBBBB_0000, 32'h3FF, '0);
    flush_i = 1'b1;
    settle();
    check("t4_count_pre", 64'(count_o), 64'd3);
    check("t4_deq_valid_flush", 64'(deq_valid_o), 64'd0);
    cyc();
    flush_i = 1'b0;
    drive_enq(1'b0, '0, '0, '0);
    settle();
    check("t4_count_post", 64'(count_o), 64'd0);
    check("t4_enq_ready_post", 64'(enq_ready_o), 64'd1);
    check("t4_valid_post", 64'(deq_valid_o), 64'd0);
    drive_enq(1'b1, 32'hC000_0000, 32'h400, '0);
    cyc();
    drive_enq(1'b0, '0, '0, '0);
    settle();
    check("t4_next_head_pc", 64'(deq_pc_o), 64'hC000_0000);
    check("t4_next_count", 64'(count_o), 64'd1);
    deq_ready_i = 1'b1;
    cyc();
    deq_ready_i = 1'b0;
    settle();
    check("t4_drained", 64'(count_o), 64'd0);

    // 5: trapped fetch locks the enqueue side until it is consumed
    drive_enq(1'b1, 32'hD000_0000, 32'h500, pf_trap);
    cyc();
    drive_enq(1'b1, 32'hD000_0004, 32'h504, '0);
    settle();
    check("t5_enq_ready_locked", 64'(enq_ready_o), 64'd0);
    check("t5_full_stall_locked", 64'(full_stall_o), 64'd1);
    check("t5_count_locked", 64'(count_o), 64'd1);
    check("t5_head_trap", 64'(deq_trap_o), 64'(pf_trap));
    cyc();
    settle();
    check("t5_count_held", 64'(count_o), 64'd1);
    check("t5_enq_ready_held", 64'(enq_ready_o), 64'd0);
    deq_ready_i = 1'b1;
    #0;
    check("t5_enq_ready_deq_cycle", 64'(enq_ready_o), 64'd0);
    cyc();
    deq_ready_i = 1'b0;
    settle();
    check("t5_count_unlocked", 64'(count_o), 64'd0);
    check("t5_enq_ready_unlocked", 64'(enq_ready_o), 64'd1);
    cyc();
    drive_enq(1'b0, '0, '0, '0);
    settle();
    check("t5_follow_count", 64'(count_o), 64'd1);
    check("t5_follow_pc", 64'(deq_pc_o), 64'hD000_0004);
    check("t5_follow_trap", 64'(deq_trap_o), 64'd0);
    deq_ready_i = 1'b1;
    cyc();
    deq_ready_i = 1'b0;
    settle();
    check("t5_drained", 64'(count_o), 64'd0);
    cyc();

    // 6: asynchronous reset mid-stream
    drive_enq(1'b1, 32'hE000_0000, 32'h600, '0);
    cyc();
    drive_enq(1'b1, 32'hE000_0004, 32'h604, '0);
    cyc();
    drive_enq(1'b0, '0, '0, '0);
    settle();
    check("t6_count_pre", 64'(count_o), 64'd2);
    check("t6_head_pre", 64'(deq_pc_o), 64'hE000_0000);
    cyc();
    #1 rst_n = 1'b0;
    #1;
    check("t6_count_async", 64'(count_o), 64'd0);
    check("t6_valid_async", 64'(deq_valid_o), 64'd0);
    check("t6_pc_async", 64'(deq_pc_o), 64'd0);
    check("t6_enq_ready_async", 64'(enq_ready_o), 64'd1);
    #4 rst_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
